adder_sequencer: RTL and testbench
==================================

Name: adder_sequencer

Overview:
- Sequential front/back-end wrapped around the 4-bit ripple full adder and its overflow detector.
- Accepts operand pairs over a valid/ready handshake and drives them onto the adder inputs.
- Holds the operands stable for a programmable settle time, because the gate-level adder has per-gate propagation delay.
- Then captures sum/carryout/overflow into output registers, presents them downstream over valid/ready, and keeps a sticky overflow flag and an operation counter.

Parameters:
- WIDTH, 4, operand/sum width in bits; must match the adder instance.
- SETTLE_CYCLES, 4, clock cycles operands are held before the result is sampled; legal range 1..255.
- COUNT_WIDTH, 8, width of the completed-operation counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  sequencer can accept an operand pair.
- in_a  input  WIDTH  first operand, 2's complement.
- in_b  input  WIDTH  second operand, 2's complement.
- add_a  output  WIDTH  registered operand driven to adder input a.
- add_b  output  WIDTH  registered operand driven to adder input b.
- add_sum  input  WIDTH  adder sum.
- add_carryout  input  1  adder carry out.
- add_overflow  input  1  adder signed-overflow flag.
- out_valid  output  1  result registers hold an undelivered result.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  captured sum.
- out_carryout  output  1  captured carry out.
- out_overflow  output  1  captured overflow.
- sticky_overflow  output  1  set by any delivered result with overflow.
- clear_sticky  input  1  synchronous clear of sticky_overflow.
- op_count  output  COUNT_WIDTH  number of results delivered, wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, regardless of state):
  - state=IDLE, settle counter=0.
  - add_a, add_b, out_sum, out_carryout, out_overflow, sticky_overflow, op_count all 0; out_valid=0.
  - in_ready=1 once reset deasserts.
  - Any in-flight operation is discarded with no output.
- States: IDLE, SETTLE, DONE.
- in_ready = (state==IDLE). It is a pure function of state, with no combinational path from out_ready.
- IDLE:
  - On an edge with in_valid=1, latch in_a/in_b into add_a/add_b, load counter=SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise hold; add_a/add_b keep their last values.
- SETTLE:
  - Counter nonzero: decrement.
  - Counter zero: capture add_sum/add_carryout/add_overflow into the out_* registers, set out_valid=1, go to DONE.
  - Latency: accept at edge k, so out_valid rises after edge k+SETTLE_CYCLES. With SETTLE_CYCLES=1 the capture is at edge k+1.
- DONE:
  - out_valid=1; out_* and add_a/add_b held stable while out_ready=0, for unbounded backpressure.
  - On an edge with out_ready=1: out_valid→0, state→IDLE, op_count+=1 (wraps), sticky_overflow |= out_overflow.
  - No new operand is accepted in the same edge; the minimum issue interval is SETTLE_CYCLES+2 cycles.
- Sticky overflow:
  - clear_sticky=1 clears it on the edge.
  - If the same edge also delivers a result with out_overflow=1, the set wins and sticky_overflow=1.
- out_* registers retain the last result after delivery until the next capture; consumers must qualify with out_valid.
- Arithmetic: the block performs no arithmetic itself; it samples the adder. Width of every data path is exactly WIDTH bits.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=2'd0, SETTLE=2'd1, DONE=2'd2).
  - Default WIDTH=4, SETTLE_CYCLES=4 and COUNT_WIDTH=8 constants.
- Natural sub-module: settle_timer.
  - Loadable down-counter with load, value and zero-flag ports.
  - Asynchronous active-high reset.
  - Counter width sized to hold SETTLE_CYCLES-1.
- The adder itself stays a separate instance outside this block.

Test Plan:
1. SETTLE_CYCLES=4. Drive in_a=4'd3, in_b=4'd4, in_valid pulse, out_ready=1 → in_ready drops next cycle; out_valid rises 4 edges after accept with out_sum=7, carryout=0, overflow=0; op_count=1; in_ready=1 the following cycle.
2. in_a=4'd7, in_b=4'd1 → out_sum=4'b1000, out_overflow=1, carryout=0. After delivery sticky_overflow=1. Next op 2+2 leaves sticky=1.
3. in_a=4'b1111, in_b=4'd1 → out_sum=0, out_carryout=1, out_overflow=0. in_a=4'b1000, in_b=4'b1000 → sum=0, carry=1, overflow=1.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid, out_* and add_a/add_b stable; in_ready=0 throughout; in_valid ignored. Releasing out_ready delivers exactly one result; op_count increments by 1.
5. Assert reset for one cycle mid-SETTLE (counter=2) → all outputs zero immediately; no out_valid afterwards. A new op 1+1 then completes normally with sum=2 and op_count=1.
6. COUNT_WIDTH=2: four delivered ops → op_count 1,2,3,0. clear_sticky asserted on the same edge as delivery of an overflowing result → sticky_overflow=1. clear_sticky alone on the next edge → 0.

Source files
------------

// File: rtl/adder_sequencer_pkg.sv
// Shared definitions for the adder sequencer: FSM state encoding, default
// parameter values and a helper that sizes the settle timer.
package adder_sequencer_pkg;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_COUNT_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } seq_state_t;

  // Bits needed to hold settle_cycles-1 (at least one bit).
  function automatic int timer_width(input int settle_cycles);
    if (settle_cycles <= 2) begin
      return 1;
    end
    return $clog2(settle_cycles);
  endfunction

endpackage

// File: rtl/adder_sequencer_settle_timer.sv
// Loadable down-counter that times how long operands sit on the adder.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   load       : load 'value' into the counter (has priority over dec)
//   dec        : decrement by one, saturating at zero
//   value      : load value
//   zero       : counter currently holds zero
module adder_sequencer_settle_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/adder_sequencer.sv
// Sequencer wrapped around an external gate-level ripple adder. Accepts an
// operand pair, holds it on the adder for SETTLE_CYCLES, captures the adder
// result and offers it downstream. Keeps a sticky overflow flag and a count
// of delivered results.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   in_valid/in_ready, in_a/in_b    : operand handshake
//   add_a/add_b                     : registered operands to the adder
//   add_sum/add_carryout/add_overflow : adder outputs
//   out_valid/out_ready, out_*      : result handshake and captured result
//   sticky_overflow, clear_sticky   : overflow history flag and its clear
//   op_count                        : delivered result count (wraps)
//
// state  | meaning
// IDLE   | ready for an operand pair
// SETTLE | operands on the adder, waiting for the ripple to settle
// DONE   | result captured, waiting for downstream to take it
module adder_sequencer
  import adder_sequencer_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_carryout,
  input  logic                   add_overflow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_sum,
  output logic                   out_carryout,
  output logic                   out_overflow,
  output logic                   sticky_overflow,
  input  logic                   clear_sticky,
  output logic [COUNT_WIDTH-1:0] op_count
);

  localparam int               CNT_W    = timer_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_t             state_q, state_d;
  logic [WIDTH-1:0]       add_a_q, add_a_d;
  logic [WIDTH-1:0]       add_b_q, add_b_d;
  logic [WIDTH-1:0]       out_sum_q, out_sum_d;
  logic                   out_carryout_q, out_carryout_d;
  logic                   out_overflow_q, out_overflow_d;
  logic                   sticky_q, sticky_d;
  logic [COUNT_WIDTH-1:0] op_count_q, op_count_d;

  logic timer_load;
  logic timer_dec;
  logic timer_zero;

  adder_sequencer_settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .dec   (timer_dec),
    .value (LOAD_VAL),
    .zero  (timer_zero)
  );

  always_comb begin
    state_d        = state_q;
    add_a_d        = add_a_q;
    add_b_d        = add_b_q;
    out_sum_d      = out_sum_q;
    out_carryout_d = out_carryout_q;
    out_overflow_d = out_overflow_q;
    sticky_d       = sticky_q;
    op_count_d     = op_count_q;
    timer_load     = 1'b0;
    timer_dec      = 1'b0;

    // Clear first so that a same-edge overflowing delivery below wins.
    if (clear_sticky) begin
      sticky_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          add_a_d    = in_a;
          add_b_d    = in_b;
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) begin
          out_sum_d      = add_sum;
          out_carryout_d = add_carryout;
          out_overflow_d = add_overflow;
          state_d        = ST_DONE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          op_count_d = op_count_q + COUNT_WIDTH'(1);
          if (out_overflow_q) begin
            sticky_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      add_a_q        <= '0;
      add_b_q        <= '0;
      out_sum_q      <= '0;
      out_carryout_q <= 1'b0;
      out_overflow_q <= 1'b0;
      sticky_q       <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      add_a_q        <= add_a_d;
      add_b_q        <= add_b_d;
      out_sum_q      <= out_sum_d;
      out_carryout_q <= out_carryout_d;
      out_overflow_q <= out_overflow_d;
      sticky_q       <= sticky_d;
      op_count_q     <= op_count_d;
    end
  end

  // Handshake flags decode straight from the state register, so there is
  // no combinational path from out_ready to in_ready.
  assign in_ready        = (state_q == ST_IDLE);
  assign out_valid       = (state_q == ST_DONE);
  assign add_a           = add_a_q;
  assign add_b           = add_b_q;
  assign out_sum         = out_sum_q;
  assign out_carryout    = out_carryout_q;
  assign out_overflow    = out_overflow_q;
  assign sticky_overflow = sticky_q;
  assign op_count        = op_count_q;

endmodule

// File: tb/tb_adder_sequencer.sv
module tb_adder_sequencer;

  localparam int W  = 4;
  localparam int S  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: SETTLE_CYCLES=4, COUNT_WIDTH=2
  logic          reset, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, add_a, add_b, add_sum, out_sum;
  logic          add_carryout, add_overflow, out_carryout, out_overflow;
  logic          sticky_overflow, clear_sticky;
  logic [CW-1:0] op_count;
  logic [W:0]    add_full;

  assign add_full     = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum      = add_full[W-1:0];
  assign add_carryout = add_full[W];
  assign add_overflow = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

  adder_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_carryout(add_carryout), .add_overflow(add_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carryout(out_carryout), .out_overflow(out_overflow),
    .sticky_overflow(sticky_overflow), .clear_sticky(clear_sticky),
    .op_count(op_count)
  );

  // Second DUT: SETTLE_CYCLES=1, COUNT_WIDTH=8
  logic          r1, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [W-1:0]  s1_in_a, s1_in_b, s1_add_a, s1_add_b, s1_add_sum, s1_out_sum;
  logic          s1_add_c, s1_add_o, s1_out_c, s1_out_o, s1_sticky, s1_clr;
  logic [7:0]    s1_count;
  logic [W:0]    s1_full;

  assign s1_full    = {1'b0, s1_add_a} + {1'b0, s1_add_b};
  assign s1_add_sum = s1_full[W-1:0];
  assign s1_add_c   = s1_full[W];
  assign s1_add_o   = (s1_add_a[W-1] == s1_add_b[W-1]) && (s1_add_sum[W-1] != s1_add_a[W-1]);

  adder_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1), .COUNT_WIDTH(8)) dut1 (
    .clk(clk), .reset(r1), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .in_a(s1_in_a), .in_b(s1_in_b), .add_a(s1_add_a), .add_b(s1_add_b),
    .add_sum(s1_add_sum), .add_carryout(s1_add_c), .add_overflow(s1_add_o),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_sum(s1_out_sum),
    .out_carryout(s1_out_c), .out_overflow(s1_out_o),
    .sticky_overflow(s1_sticky), .clear_sticky(s1_clr), .op_count(s1_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0] sum;
    logic       c;
    logic       o;
  } res_t;

  res_t sb_q[$];

  // Reference: unsigned sum modulo 16, carry = unsigned sum beyond 15,
  // overflow = signed sum outside [-8,7].
  function automatic res_t ref_add(input int a, input int b);
    res_t r;
    int s, sa, sb;
    s  = a + b;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r.sum = 4'(s % 16);
    r.c   = (s > 15);
    r.o   = ((sa + sb) > 7) || ((sa + sb) < -8);
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever a result is handed off.
  always @(negedge clk) begin
    res_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty unexpected result sum=%0d", out_sum);
      end else begin
        e = sb_q.pop_front();
        chk("sb_sum", out_sum, e.sum);
        chk("sb_carry", out_carryout, e.c);
        chk("sb_ovf", out_overflow, e.o);
      end
    end
  end

  int   mdl_count;
  logic mdl_sticky;
  bit   s1_done = 0;

  task automatic do_op(input int a, input int b, input int stall, input bit clr);
    res_t e;
    int n, lat;
    logic [3:0] hs;
    @(posedge clk); #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    e = ref_add(a, b);
    sb_q.push_back(e);
    in_valid = 1'b1;
    in_a = 4'(a);
    in_b = 4'(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 4'($urandom);
    in_b = 4'($urandom);
    @(negedge clk);
    chk("in_ready_drop", in_ready, 0);
    chk("add_a", add_a, a);
    chk("add_b", add_b, b);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, S);
    hs = out_sum;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a = 4'($urandom);
      in_b = 4'($urandom);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", out_sum, hs);
      chk("bp_add_a", add_a, a);
      chk("bp_add_b", add_b, b);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    clear_sticky = clr;
    @(posedge clk); #1;
    out_ready = 1'b0;
    clear_sticky = 1'b0;
    mdl_count++;
    mdl_sticky = (clr ? 1'b0 : mdl_sticky) | e.o;
    @(negedge clk);
    chk("deliver_valid", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
    chk("op_count", op_count, mdl_count % 4);
    chk("sticky", sticky_overflow, mdl_sticky);
    chk("hold_sum", out_sum, e.sum);
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
    in_a = '0; in_b = '0;
    mdl_count = 0; mdl_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_carry", out_carryout, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_sticky", sticky_overflow, 0);
    chk("rst_count", op_count, 0);

    do_op(3, 4, 0, 0);
    do_op(7, 1, 0, 0);
    do_op(2, 2, 0, 0);
    do_op(15, 1, 0, 0);
    do_op(8, 8, 0, 0);
    do_op(5, 6, 10, 0);

    // set-wins when clear coincides with an overflowing delivery
    do_op(7, 7, 0, 1);
    @(posedge clk); #1 clear_sticky = 1'b1;
    @(posedge clk); #1 clear_sticky = 1'b0;
    mdl_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_clear_alone", sticky_overflow, 0);
    do_op(6, 6, 0, 0);
    do_op(1, 2, 0, 1);
    do_op(4, 4, 0, 0);

    // reset in the middle of SETTLE
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_settling", out_valid, 0);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_add_a", add_a, 0);
    chk("midrst_add_b", add_b, 0);
    chk("midrst_out_sum", out_sum, 0);
    chk("midrst_ovf", out_overflow, 0);
    chk("midrst_sticky", sticky_overflow, 0);
    chk("midrst_count", op_count, 0);
    @(posedge clk); #1 reset = 1'b0;
    mdl_count = 0;
    mdl_sticky = 1'b0;
    for (int i = 0; i < S + 3; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", out_valid, 0);
    end
    do_op(1, 1, 0, 0);

    repeat (30) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    n = 0;
    while (!s1_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("s1_finished", s1_done, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // SETTLE_CYCLES=1: capture one edge after accept, back-to-back issue every 3 cycles.
  initial begin
    r1 = 1'b1; s1_in_valid = 1'b0; s1_out_ready = 1'b1; s1_clr = 1'b0;
    s1_in_a = '0; s1_in_b = '0;
    repeat (2) @(posedge clk);
    #1 r1 = 1'b0;
    s1_in_valid = 1'b1; s1_in_a = 4'd7; s1_in_b = 4'd1;
    @(posedge clk); #1;
    s1_in_a = 4'd2; s1_in_b = 4'd3;
    @(negedge clk);
    chk("s1_in_ready_drop", s1_in_ready, 0);
    @(negedge clk);
    chk("s1_valid_lat1", s1_out_valid, 1);
    chk("s1_sum", s1_out_sum, 8);
    chk("s1_carry", s1_out_c, 0);
    chk("s1_ovf", s1_out_o, 1);
    @(negedge clk);
    chk("s1_delivered", s1_out_valid, 0);
    chk("s1_in_ready", s1_in_ready, 1);
    chk("s1_count1", s1_count, 1);
    chk("s1_sticky", s1_sticky, 1);
    @(negedge clk);
    chk("s1_second_accept", s1_in_ready, 0);
    chk("s1_add_a2", s1_add_a, 2);
    s1_in_valid = 1'b0;
    @(negedge clk);
    chk("s1_valid2", s1_out_valid, 1);
    chk("s1_sum2", s1_out_sum, 5);
    @(negedge clk);
    chk("s1_count2", s1_count, 2);
    s1_done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
